requant_stage: RTL and testbench
================================

Name: requant_stage

Overview:
- Parametrised successor to the layer-output truncation stage. It converts a layer's full-precision products (2*DATAWIDTH-bit, Q(INT_IN+INT_WT)) into DATAWIDTH-bit outputs in a configurable output Q-format.
- Rounding mode is selectable at run time, and saturation is done correctly against the output range.
- LANES rows are processed per cycle, and saturation events are counted.
- Sits between the MAC array and the next layer's input buffer, using the same layer_done/trunc_done level handshake.

Parameters:
ROWS, 30, rows per layer vector
DATAWIDTH, 11, output word width; input word width is 2*DATAWIDTH
INT_IN, 5, integer bits (incl. sign) of layer input operand
INT_WT, 5, integer bits (incl. sign) of weight operand
INT_OUT, 5, integer bits (incl. sign) of output word
LANES, 4, rows converted per cycle (1..ROWS)

Ports:
clk  in  1  clock
rst_overall_n  in  1  asynchronous active-low reset
clr_vals  in  1  synchronous active-high soft clear (same effect as reset, applied at clk edge)
layer_done  in  1  level request; layer_out_pre valid and stable while high
round_mode  in  2  0=truncate (floor), 1=round-half-up, 2=round-half-even, 3=reserved (treated as 0)
layer_out_pre  in  ROWS*2*DATAWIDTH  signed products; row i at [i*2*DATAWIDTH +: 2*DATAWIDTH]
layer_out_trunc  out  ROWS*DATAWIDTH  requantised rows; row i at [i*DATAWIDTH +: DATAWIDTH]
trunc_done  out  1  level, high from completion until layer_done drops
busy  out  1  high in PROCESS
sat_count  out  $clog2(ROWS+1)  rows saturated in the current/last layer
sat_any  out  1  sat_count != 0

Behaviour:
- Reset (async, rst_overall_n=0) or clr_vals=1 at an edge: layer_out_trunc=0, trunc_done=0, busy=0, sat_count=0, state=IDLE, row_cnt=0, mode_q=0. clr_vals overrides all other inputs.
- Constants:
  - FI=DATAWIDTH-INT_IN, FW=DATAWIDTH-INT_WT, FO=DATAWIDTH-INT_OUT.
  - S=FI+FW-FO; elaboration error if S<1.
- Per-row arithmetic, x = signed 2*DATAWIDTH row value, computed at 2*DATAWIDTH+1 bits with no intermediate overflow:
  - mode 0: y = x >>> S
  - mode 1: y = (x + 2^(S-1)) >>> S
  - mode 2: y = (x + 2^(S-1) - 1 + x[S]) >>> S
  - Saturate y to [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1]. Each clipped row increments sat_count by 1 (lane increments summed per cycle).
- FSM:
  - IDLE: if layer_done=1, latch round_mode into mode_q, clear row_cnt and sat_count, go to PROCESS. layer_out_trunc holds the previous layer's result until overwritten.
  - PROCESS: busy=1. Lane l (0..LANES-1) converts row index ROWS-1-(row_cnt+l) if row_cnt+l<ROWS; otherwise the lane is idle and does not write. row_cnt += LANES. On the edge that writes the last batch: trunc_done<=1, go to DONE.
  - DONE: hold outputs. When layer_done=0: trunc_done<=0, go to IDLE.
- Latency: with layer_done sampled high in IDLE at edge k, trunc_done is visible after edge k+ceil(ROWS/LANES).
- layer_done dropping during PROCESS does not abort the layer. On reaching DONE with layer_done already low, the block returns to IDLE on the next edge, so trunc_done pulses for 1 cycle.
- round_mode changes during PROCESS have no effect (mode_q is used).
- Reset or clr_vals mid-PROCESS aborts immediately, with all outputs set to their reset values.
- layer_out_pre changing during PROCESS gives undefined results (caller's responsibility).

Test Plan:
Use defaults (S=6) unless noted; each scenario drives 0 on all rows except those listed.
- Mode sweep, row0: x=96 -> mode0 1, mode1 2, mode2 2. x=32 -> 0/1/0. x=-32 -> -1 (0x7FF) / 0 / 0. x=64 -> 1 in all modes.
- Saturation: row3 x=65536 -> 0x3FF, row4 x=-65600 -> 0x400 -> sat_count=2, sat_any=1. Next layer with all rows 0 -> sat_count=0.
- Latency and partial batch: ROWS=30, LANES=4, layer_done rises before edge k. Expect busy for 8 cycles, trunc_done after edge k+8, all 30 rows correct, no write beyond row 0. Repeat with LANES=1 (30 cycles) and LANES=30 (1 cycle).
- Handshake: hold layer_done high 5 cycles past done -> trunc_done stays high, no restart. Drop layer_done -> trunc_done low next edge. Raise again -> new layer starts. round_mode toggled mid-PROCESS -> result still uses latched mode.
- Reset mid-operation: assert rst_overall_n=0 asynchronously at PROCESS cycle 3 -> outputs 0 immediately, without waiting for a clock edge. clr_vals=1 at cycle 3 -> outputs 0 after that edge. In both cases a following layer completes normally.
- Format change: INT_OUT=4 (S=5), x=48 -> mode0 1, mode1 2, mode2 2.

Source files
------------

// File: rtl/requant_stage.sv
// requant_stage: requantises ROWS wide signed products to DATAWIDTH-bit words, LANES rows per cycle,
// with run-time rounding mode, saturation and a per-layer saturation count.
module requant_stage #(
    parameter int ROWS      = 30,
    parameter int DATAWIDTH = 11,
    parameter int INT_IN    = 5,
    parameter int INT_WT    = 5,
    parameter int INT_OUT   = 5,
    parameter int LANES     = 4
) (
    input  logic                            clk,
    input  logic                            rst_overall_n,
    input  logic                            clr_vals,
    input  logic                            layer_done,
    input  logic [1:0]                      round_mode,
    input  logic [ROWS*2*DATAWIDTH-1:0]     layer_out_pre,
    output logic [ROWS*DATAWIDTH-1:0]       layer_out_trunc,
    output logic                            trunc_done,
    output logic                            busy,
    output logic [$clog2(ROWS+1)-1:0]       sat_count,
    output logic                            sat_any
);
    localparam int DW = DATAWIDTH;
    localparam int IW = 2 * DATAWIDTH;
    localparam int S  = (DW - INT_IN) + (DW - INT_WT) - (DW - INT_OUT);
    localparam int CW = $clog2(ROWS + 1);
    localparam int RW = $clog2(ROWS + LANES + 1);
    localparam logic signed [IW:0] HALF    = (IW+1)'(1) << (S - 1);
    localparam logic signed [IW:0] HALF_M1 = HALF - (IW+1)'(1);
    localparam logic signed [IW:0] HI      = (IW+1)'((64'(1) << (DW - 1)) - 64'(1));
    localparam logic signed [IW:0] LO      = ~HI;

    typedef enum logic [1:0] {S_IDLE, S_PROC, S_DONE} state_t;

    if (S < 1) begin : g_bad_shift
        $error("requant_stage: output format leaves shift S < 1");
    end

    // Returns {saturated, word}; the sum is one bit wider than x so the rounding add cannot overflow.
    function automatic logic [DW:0] conv(input logic [IW-1:0] x, input logic [1:0] m);
        logic signed [IW:0] xe, add, y;
        xe  = {x[IW-1], x};
        add = (m == 2'd1) ? HALF : (m == 2'd2) ? HALF_M1 + (IW+1)'(xe[S]) : '0;
        y   = (xe + add) >>> S;
        return (y > HI) ? {1'b1, HI[DW-1:0]} : (y < LO) ? {1'b1, LO[DW-1:0]} : {1'b0, y[DW-1:0]};
    endfunction

    state_t              r_state;
    logic [RW-1:0]       r_row_cnt;
    logic [1:0]          r_mode;
    logic [ROWS*DW-1:0]  r_out;
    logic                r_done;
    logic [CW-1:0]       r_sat;
    logic [LANES-1:0]    w_act;
    logic [RW-1:0]       w_idx [LANES];
    logic [DW:0]         w_res [LANES];
    logic [CW-1:0]       w_sat_inc;

    always_comb begin
        w_sat_inc = '0;
        for (int l = 0; l < LANES; l++) begin
            w_act[l]  = (r_row_cnt + RW'(l)) < RW'(ROWS);
            w_idx[l]  = w_act[l] ? RW'(ROWS - 1) - r_row_cnt - RW'(l) : '0;
            w_res[l]  = conv(layer_out_pre[w_idx[l]*IW +: IW], r_mode);
            w_sat_inc = w_sat_inc + CW'(w_act[l] & w_res[l][DW]);
        end
    end

    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) begin
            r_state   <= S_IDLE;
            r_row_cnt <= '0;
            r_mode    <= '0;
            r_out     <= '0;
            r_done    <= 1'b0;
            r_sat     <= '0;
        end else if (clr_vals) begin
            r_state   <= S_IDLE;
            r_row_cnt <= '0;
            r_mode    <= '0;
            r_out     <= '0;
            r_done    <= 1'b0;
            r_sat     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (layer_done) begin
                    r_mode    <= round_mode;
                    r_row_cnt <= '0;
                    r_sat     <= '0;
                    r_state   <= S_PROC;
                end
                S_PROC: begin
                    for (int l = 0; l < LANES; l++)
                        if (w_act[l]) r_out[w_idx[l]*DW +: DW] <= w_res[l][DW-1:0];
                    r_row_cnt <= r_row_cnt + RW'(LANES);
                    r_sat     <= r_sat + w_sat_inc;
                    if (r_row_cnt + RW'(LANES) >= RW'(ROWS)) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: if (!layer_done) begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign layer_out_trunc = r_out;
    assign trunc_done      = r_done;
    assign busy            = (r_state == S_PROC);
    assign sat_count       = r_sat;
    assign sat_any         = |r_sat;
endmodule

// File: tb/tb_requant_stage.sv
// tb_requant_stage: directed scoreboard bench; u_a uses defaults, u_b is INT_OUT=4/LANES=30, u_c is LANES=1.
module tb_requant_stage;
    localparam int ROWS = 30;
    localparam int DW   = 11;
    localparam int IW   = 22;
    localparam int CW   = $clog2(ROWS + 1);

    typedef struct {
        logic [ROWS*DW-1:0] v;
        int                 sat;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, ld = 1'b0, ld2 = 1'b0;
    logic [1:0] rm = '0, rm2 = '0;
    logic [ROWS*IW-1:0] pre = '0, pre2 = '0;
    logic [ROWS*DW-1:0] out_a, out_b, out_c;
    logic done_a, done_b, done_c, busy_a, busy_b, busy_c, any_a, any_b, any_c;
    logic [CW-1:0] sat_a, sat_b, sat_c;
    logic pa = 1'b0, pb = 1'b0, pc = 1'b0;
    exp_t q_a[$], q_b[$], q_c[$];
    int total = 0, bad = 0;

    int r_sw[5]  = '{0, 1, 2, 3, 29};
    int x_sw[5]  = '{96, 32, -32, 64, 160};
    int e_m0[5]  = '{1, 0, -1, 1, 2};
    int e_m1[5]  = '{2, 1, 0, 1, 3};
    int e_m2[5]  = '{2, 0, 0, 1, 2};
    int r_sat[5] = '{3, 4, -1, -1, -1};
    int x_sat[5] = '{65536, -65600, 0, 0, 0};
    int e_sat[5] = '{1023, -1024, 0, 0, 0};
    int zero5[5] = '{0, 0, 0, 0, 0};
    int r_h[5]   = '{0, 29, -1, -1, -1};
    int x_h[5]   = '{96, 96, 0, 0, 0};
    int e_h[5]   = '{2, 2, 0, 0, 0};
    int x_f[5]   = '{48, 96, 0, 0, 0};
    int eb0[5]   = '{1, 3, 0, 0, 0};
    int eb1[5]   = '{2, 3, 0, 0, 0};
    int eb2[5]   = '{2, 3, 0, 0, 0};
    int ec0[5]   = '{0, 1, 0, 0, 0};
    int ec1[5]   = '{1, 2, 0, 0, 0};
    int ec2[5]   = '{1, 2, 0, 0, 0};

    always #5 clk = ~clk;

    requant_stage u_a (
        .clk(clk), .rst_overall_n(rst_n), .clr_vals(clr), .layer_done(ld), .round_mode(rm),
        .layer_out_pre(pre), .layer_out_trunc(out_a), .trunc_done(done_a), .busy(busy_a),
        .sat_count(sat_a), .sat_any(any_a)
    );
    requant_stage #(.INT_OUT(4), .LANES(30)) u_b (
        .clk(clk), .rst_overall_n(rst_n), .clr_vals(clr), .layer_done(ld2), .round_mode(rm2),
        .layer_out_pre(pre2), .layer_out_trunc(out_b), .trunc_done(done_b), .busy(busy_b),
        .sat_count(sat_b), .sat_any(any_b)
    );
    requant_stage #(.LANES(1)) u_c (
        .clk(clk), .rst_overall_n(rst_n), .clr_vals(clr), .layer_done(ld2), .round_mode(rm2),
        .layer_out_pre(pre2), .layer_out_trunc(out_c), .trunc_done(done_c), .busy(busy_c),
        .sat_count(sat_c), .sat_any(any_c)
    );

    task automatic chk(input string nm, input logic [399:0] act, input logic [399:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_chk(input string nm, input exp_t e, input logic [ROWS*DW-1:0] v,
                          input logic [CW-1:0] s, input logic a);
        chk({nm, "_rows"}, v, e.v);
        chk({nm, "_sat_count"}, s, e.sat);
        chk({nm, "_sat_any"}, a, e.sat != 0);
    endtask

    function automatic logic [ROWS*IW-1:0] mk_pre(input int r[5], input int x[5]);
        logic [ROWS*IW-1:0] v = '0;
        for (int i = 0; i < 5; i++) if (r[i] >= 0) v[r[i]*IW +: IW] = IW'(x[i]);
        return v;
    endfunction

    function automatic logic [ROWS*DW-1:0] mk_exp(input int r[5], input int e[5]);
        logic [ROWS*DW-1:0] v = '0;
        for (int i = 0; i < 5; i++) if (r[i] >= 0) v[r[i]*DW +: DW] = DW'(e[i]);
        return v;
    endfunction

    always @(negedge clk) begin
        if (done_a && !pa) begin
            if (q_a.size() == 0) chk("a_spurious_done", 1, 0);
            else sb_chk("a", q_a.pop_front(), out_a, sat_a, any_a);
        end
        pa = done_a;
    end

    always @(negedge clk) begin
        if (done_b && !pb) begin
            if (q_b.size() == 0) chk("b_spurious_done", 1, 0);
            else sb_chk("b", q_b.pop_front(), out_b, sat_b, any_b);
        end
        pb = done_b;
    end

    always @(negedge clk) begin
        if (done_c && !pc) begin
            if (q_c.size() == 0) chk("c_spurious_done", 1, 0);
            else sb_chk("c", q_c.pop_front(), out_c, sat_c, any_c);
        end
        pc = done_c;
    end

    // round_mode is flipped mid-layer so every result also proves the latched mode is used.
    task automatic run_a(input logic [1:0] mode, input int r[5], input int x[5], input int e[5],
                         input int s, input int hold);
        exp_t ex;
        int n, nb, hi;
        @(negedge clk);
        pre = mk_pre(r, x);
        rm = mode;
        ex.v = mk_exp(r, e);
        ex.sat = s;
        q_a.push_back(ex);
        ld = 1'b1;
        n = 0;
        nb = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            nb += int'(busy_a);
            if (n == 2) rm = mode ^ 2'b01;
        end while (!done_a && n < 100);
        chk("a_latency", n - 1, 8);
        chk("a_busy_cycles", nb, 8);
        hi = 0;
        repeat (hold) begin
            @(negedge clk);
            hi += int'(done_a && !busy_a);
        end
        if (hold > 0) chk("a_hold_done", hi, hold);
        ld = 1'b0;
        @(negedge clk);
        chk("a_done_drop", done_a, 0);
    endtask

    task automatic run_bc(input logic [1:0] mode, input int eb[5], input int ec[5]);
        exp_t ex;
        int n, lb, lc;
        @(negedge clk);
        pre2 = mk_pre(r_h, x_f);
        rm2 = mode;
        ex.sat = 0;
        ex.v = mk_exp(r_h, eb);
        q_b.push_back(ex);
        ex.v = mk_exp(r_h, ec);
        q_c.push_back(ex);
        ld2 = 1'b1;
        n = 0;
        lb = 0;
        lc = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) rm2 = mode ^ 2'b01;
            if (done_b && lb == 0) lb = n;
            if (done_c && lc == 0) lc = n;
        end while ((lb == 0 || lc == 0) && n < 100);
        chk("b_latency", lb - 1, 1);
        chk("c_latency", lc - 1, 30);
        ld2 = 1'b0;
        @(negedge clk);
        chk("bc_done_drop", {done_b, done_c}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", {out_a, done_a, busy_a, sat_a, any_a}, 0);
        rst_n = 1'b1;
        run_a(2'd0, r_sw, x_sw, e_m0, 0, 0);
        run_a(2'd1, r_sw, x_sw, e_m1, 0, 0);
        run_a(2'd2, r_sw, x_sw, e_m2, 0, 0);
        run_a(2'd3, r_sw, x_sw, e_m0, 0, 0);
        run_a(2'd0, r_sat, x_sat, e_sat, 2, 5);
        run_a(2'd1, r_sat, zero5, zero5, 0, 0);
        run_a(2'd0, r_sat, x_sat, e_sat, 2, 0);
        @(negedge clk);
        pre = mk_pre(r_sw, x_sw);
        ld = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("a_async_reset", {out_a, done_a, busy_a, sat_a, any_a}, 0);
        ld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_a(2'd1, r_h, x_h, e_h, 0, 0);
        @(negedge clk);
        pre = mk_pre(r_sw, x_sw);
        ld = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        ld = 1'b0;
        #1;
        chk("a_clr_waits_edge", busy_a, 1);
        @(negedge clk);
        chk("a_clr_clears", {out_a, done_a, busy_a, sat_a, any_a}, 0);
        clr = 1'b0;
        run_a(2'd2, r_sw, x_sw, e_m2, 0, 0);
        run_bc(2'd0, eb0, ec0);
        run_bc(2'd1, eb1, ec1);
        run_bc(2'd2, eb2, ec2);
        @(negedge clk);
        chk("queues_drained", q_a.size() + q_b.size() + q_c.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
